// File: rtl/inst_fetch.sv
// Instruction-fetch front end: owns the program counter, drives the ROM read
// port and pairs the ROM's one-cycle registered data with the PC that produced
// it. Supports decode stalls (word captured in a hold register) and branch
// redirects with a single bubble.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall_i,
  input  logic        branch_i,
  input  logic [31:0] branch_target_i,
  output logic [31:0] pc_o,
  output logic        ce_o,
  input  logic [31:0] inst_i,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_inst_o,
  output logic        id_valid_o
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StHold  = 2'd2,
    StRedir = 2'd3
  } state_e;

  state_e      r_state;
  state_e      w_state_d;

  logic [31:0] r_pc;
  logic [31:0] r_fpc;
  logic        r_valid;
  logic [31:0] r_hold;
  logic        r_ce;

  logic [31:0] w_target;
  logic        w_redirect;
  logic        w_advance;
  logic        w_capture;

  assign w_target = {branch_target_i[31:2], 2'b00};

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Next-state logic: branch beats stall beats advance.
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle: begin
        w_state_d = StRun;
      end
      StRun, StHold, StRedir: begin
        if (branch_i) begin
          w_state_d = StRedir;
        end else if (stall_i) begin
          w_state_d = StHold;
        end else begin
          w_state_d = StRun;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Control decode: which datapath update happens at the coming edge.
  always_comb begin
    w_redirect = branch_i;
    w_advance  = 1'b0;
    w_capture  = 1'b0;
    unique case (r_state)
      StIdle: begin
        // Idle only enables the ROM; the PC is not advanced.
        w_advance = 1'b0;
      end
      StRun, StRedir: begin
        w_advance = !branch_i && !stall_i;
        w_capture = !branch_i && stall_i;
      end
      StHold: begin
        // Hold register already owns the word; only release advances.
        w_advance = !branch_i && !stall_i;
      end
      default: begin
        w_advance = 1'b0;
      end
    endcase
  end

  // Datapath registers: PC, fetched PC, valid, captured word and ROM enable.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pc    <= RESET_PC;
      r_fpc   <= RESET_PC;
      r_valid <= 1'b0;
      r_hold  <= 32'h0;
      r_ce    <= 1'b0;
    end else begin
      r_ce <= 1'b1;
      if (w_redirect) begin
        // Kill the word already in flight from the old PC.
        r_pc    <= w_target;
        r_valid <= 1'b0;
        r_hold  <= 32'h0;
      end else if (w_advance) begin
        r_fpc   <= r_pc;
        r_pc    <= r_pc + 32'd4;
        r_valid <= 1'b1;
      end else if (w_capture) begin
        // ROM will re-read r_pc during the hold, so only this word needs saving.
        r_hold <= inst_i;
      end
    end
  end

  // Decode-side outputs and ROM port.
  always_comb begin
    pc_o       = r_pc;
    ce_o       = r_ce;
    id_pc_o    = r_fpc;
    id_valid_o = r_valid;
    id_inst_o  = 32'h0;
    if (r_valid) begin
      id_inst_o = (r_state == StHold) ? r_hold : inst_i;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: behavioural ROM, a table of per-edge vectors whose
// expected triples feed a scoreboard queue, plus hand-written reset checks.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        stall_i;
  logic        branch_i;
  logic [31:0] branch_target_i;
  logic [31:0] pc_o;
  logic        ce_o;
  logic [31:0] inst_i = 32'h0;
  logic [31:0] id_pc_o;
  logic [31:0] id_inst_o;
  logic        id_valid_o;

  int n_vec = 0;
  int n_bad = 0;

  inst_fetch #(
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .stall_i        (stall_i),
    .branch_i       (branch_i),
    .branch_target_i(branch_target_i),
    .pc_o           (pc_o),
    .ce_o           (ce_o),
    .inst_i         (inst_i),
    .id_pc_o        (id_pc_o),
    .id_inst_o      (id_inst_o),
    .id_valid_o     (id_valid_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [29:0] idx);
    return {idx[15:0], ~idx[15:0]} ^ 32'h5A5A_0000;
  endfunction

  // ROM: registered read, zero when disabled.
  always_ff @(posedge clk) begin
    inst_i <= ce_o ? rom_word(pc_o[31:2]) : 32'h0;
  end

  typedef struct {
    logic        stall;
    logic        br;
    logic [31:0] tgt;
    logic        ev;
    logic [31:0] eid;
    logic [31:0] epc;
    logic        ece;
  } vec_t;

  typedef struct {
    int          idx;
    logic        ev;
    logic [31:0] eid;
    logic [31:0] einst;
    logic [31:0] epc;
    logic        ece;
  } exp_t;

  vec_t vecs[25];
  exp_t sb[$];

  task automatic check(input string nm, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s vec=%0d actual=%08h required=%08h", nm, idx, act, exp);
    end
  endtask

  // Drive one vector at a negedge, score the outputs just after the next posedge.
  task automatic run_vec(input int i);
    exp_t e;
    stall_i         = vecs[i].stall;
    branch_i        = vecs[i].br;
    branch_target_i = vecs[i].tgt;
    e.idx   = i;
    e.ev    = vecs[i].ev;
    e.eid   = vecs[i].eid;
    e.einst = vecs[i].ev ? rom_word(vecs[i].eid[31:2]) : 32'h0;
    e.epc   = vecs[i].epc;
    e.ece   = vecs[i].ece;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL scoreboard_empty vec=%0d actual=0 required=1", i);
    end else begin
      e = sb.pop_front();
      check("id_valid", e.idx, {31'h0, id_valid_o}, {31'h0, e.ev});
      check("id_pc", e.idx, id_pc_o, e.eid);
      check("id_inst", e.idx, id_inst_o, e.einst);
      check("pc", e.idx, pc_o, e.epc);
      check("ce", e.idx, {31'h0, ce_o}, {31'h0, e.ece});
    end
    @(negedge clk);
  endtask

  task automatic check_reset_state(input string nm);
    check({nm, "_ce"}, -1, {31'h0, ce_o}, 32'h0);
    check({nm, "_valid"}, -1, {31'h0, id_valid_o}, 32'h0);
    check({nm, "_inst"}, -1, id_inst_o, 32'h0);
    check({nm, "_pc"}, -1, pc_o, 32'h0);
    check({nm, "_id_pc"}, -1, id_pc_o, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //            stall br  tgt            ev   id_pc          pc_o           ce
    vecs[0]  = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        32'h0,        1'b1};
    vecs[1]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h0,        32'h4,        1'b1};
    vecs[2]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h4,        32'h8,        1'b1};
    vecs[3]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h8,        32'hC,        1'b1};
    vecs[4]  = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h8,        32'hC,        1'b1};
    vecs[5]  = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h8,        32'hC,        1'b1};
    vecs[6]  = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h8,        32'hC,        1'b1};
    vecs[7]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'hC,        32'h10,       1'b1};
    vecs[8]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h10,       32'h14,       1'b1};
    vecs[9]  = '{1'b0, 1'b1, 32'h40,       1'b0, 32'h10,       32'h40,       1'b1};
    vecs[10] = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h40,       32'h44,       1'b1};
    vecs[11] = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h44,       32'h48,       1'b1};
    vecs[12] = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h44,       32'h48,       1'b1};
    vecs[13] = '{1'b1, 1'b1, 32'h23,       1'b0, 32'h44,       32'h20,       1'b1};
    vecs[14] = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h20,       32'h24,       1'b1};
    vecs[15] = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h24,       32'h28,       1'b1};
    vecs[16] = '{1'b0, 1'b1, 32'hFFFFFFFC, 1'b0, 32'h24,       32'hFFFFFFFC, 1'b1};
    vecs[17] = '{1'b0, 1'b0, 32'h0,        1'b1, 32'hFFFFFFFC, 32'h0,        1'b1};
    vecs[18] = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h0,        32'h4,        1'b1};
    vecs[19] = '{1'b0, 1'b1, 32'h100,      1'b0, 32'h0,        32'h100,      1'b1};
    vecs[20] = '{1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        32'h100,      1'b1};
    vecs[21] = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h100,      32'h104,      1'b1};
    vecs[22] = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h100,      32'h104,      1'b1};
    // Branch while idle, right after a reset.
    vecs[23] = '{1'b0, 1'b1, 32'h80,       1'b0, 32'h0,        32'h80,       1'b1};
    vecs[24] = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h80,       32'h84,       1'b1};

    reset_n         = 1'b0;
    stall_i         = 1'b0;
    branch_i        = 1'b0;
    branch_target_i = 32'h0;
    repeat (3) @(negedge clk);
    check_reset_state("por");
    reset_n = 1'b1;

    // Reset release, run, stall, branch, stall+branch, wrap, stall in bubble.
    for (int i = 0; i <= 22; i++) begin
      run_vec(i);
    end

    // Async reset while holding: immediate return to reset values.
    reset_n = 1'b0;
    #1;
    check_reset_state("hold_rst");
    @(negedge clk);
    check_reset_state("hold_rst_edge");
    stall_i = 1'b0;
    reset_n = 1'b1;
    for (int i = 0; i <= 3; i++) begin
      run_vec(i);
    end

    // Another reset, then branch on the very first edge.
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 23; i <= 24; i++) begin
      run_vec(i);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
